// File: rtl/fsm_step_ctrl.sv
// fsm_step_ctrl
// Sequencing controller for the five-step pattern FSM (step index 0..4,
// step 4 terminal). Two requesters share the pattern FSM through a
// round-robin arbiter. Each granted request runs one command to
// completion, then done pulses for one cycle.
//
// Commands: 00 ADVANCE n steps, 01 HOLD n cycles, 10 RESTART,
//           11 reserved (runs as HOLD).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_x/cmd_x/cnt_x   requester x (a or b): request, command, count
//   fsm_num             current step index reported by the pattern FSM
//   gnt_a/gnt_b         requester owns the pattern FSM (never both high)
//   done_a/done_b       one-cycle completion pulse to the owner
//   pause/restart       registered controls to the pattern FSM
//   goto_third          combinational; wraps step 4 back to step 2
//   busy                high in GRANT, EXEC and DONE
//   err                 sticky: illegal fsm_num (5..7) seen while advancing
//
// Handshake: a requester raises req_x with cmd_x/cnt_x stable and keeps it
// high until it sees done_x. It must drop req_x in the cycle after done_x;
// a req_x still high when IDLE samples again is taken as a new request.
// Requests are sampled only in IDLE, so cmd/cnt may change once granted.
module fsm_step_ctrl #(
  parameter int unsigned CNT_W      = 4,
  parameter bit          IDLE_PAUSE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [1:0]       cmd_a,
  input  logic [CNT_W-1:0] cnt_a,
  input  logic             req_b,
  input  logic [1:0]       cmd_b,
  input  logic [CNT_W-1:0] cnt_b,
  input  logic [2:0]       fsm_num,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic             pause,
  output logic             restart,
  output logic             goto_third,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_EXEC    = 3'd2,
    S_RECOVER = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CMD_ADV     = 2'b00,
    CMD_HOLD    = 2'b01,
    CMD_RESTART = 2'b10
  } cmd_e;

  // owner encoding: 0 = requester A, 1 = requester B
  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  cmd_e             cmd_q, cmd_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             err_q, err_d;

  logic gnt_a_d, gnt_b_d, done_a_d, done_b_d, pause_d, restart_d, busy_d;

  logic [1:0]       sel_cmd;
  logic [CNT_W-1:0] sel_cnt;
  logic             sel_owner;
  logic             fsm_bad;

  assign fsm_bad = (fsm_num > 3'd4);

  // Tie goes to whoever was not served last; a lone request wins outright.
  always_comb begin
    sel_owner = 1'b0;
    if (req_a && req_b) begin
      sel_owner = ~last_q;
    end else if (req_b) begin
      sel_owner = 1'b1;
    end
    sel_cmd = sel_owner ? cmd_b : cmd_a;
    sel_cnt = sel_owner ? cnt_b : cnt_a;
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cmd_d    = cmd_q;
    remain_d = remain_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          owner_d  = sel_owner;
          cmd_d    = (sel_cmd == 2'b11) ? CMD_HOLD : cmd_e'(sel_cmd);
          remain_d = sel_cnt;
          state_d  = S_GRANT;
        end
      end
      S_GRANT: begin
        if (cmd_q == CMD_RESTART) begin
          // restart is a single drive cycle whatever the count says
          remain_d = CNT_W'(1);
          state_d  = S_EXEC;
        end else if (remain_q == '0) begin
          state_d = S_DONE;
        end else if (cmd_q == CMD_ADV && fsm_bad) begin
          // never release pause on an FSM reporting an illegal step
          err_d   = 1'b1;
          state_d = S_RECOVER;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cmd_q == CMD_ADV && fsm_bad) begin
          err_d   = 1'b1;
          state_d = S_RECOVER;
        end else begin
          remain_d = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_RECOVER: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the state being entered so they line up
    // with that state once registered.
    gnt_a_d   = (state_d != S_IDLE) && !owner_d;
    gnt_b_d   = (state_d != S_IDLE) && owner_d;
    done_a_d  = (state_d == S_DONE) && !owner_d;
    done_b_d  = (state_d == S_DONE) && owner_d;
    busy_d    = (state_d == S_GRANT) || (state_d == S_EXEC) || (state_d == S_DONE);
    restart_d = (state_d == S_RECOVER) ||
                ((state_d == S_EXEC) && (cmd_d == CMD_RESTART));
    if (state_d == S_EXEC) begin
      pause_d = (cmd_d != CMD_ADV);
    end else if (state_d == S_RECOVER) begin
      pause_d = 1'b1;
    end else begin
      pause_d = IDLE_PAUSE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;   // B counts as last served, so A wins the first tie
      cmd_q    <= CMD_HOLD;
      remain_q <= '0;
      err_q    <= 1'b0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      done_a   <= 1'b0;
      done_b   <= 1'b0;
      pause    <= IDLE_PAUSE;
      restart  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cmd_q    <= cmd_d;
      remain_q <= remain_d;
      err_q    <= err_d;
      gnt_a    <= gnt_a_d;
      gnt_b    <= gnt_b_d;
      done_a   <= done_a_d;
      done_b   <= done_b_d;
      pause    <= pause_d;
      restart  <= restart_d;
      busy     <= busy_d;
    end
  end

  assign err = err_q;

  // Wrap 4 -> 2 in the same cycle the FSM reports step 4.
  assign goto_third = (state_q == S_EXEC) && (cmd_q == CMD_ADV) && (fsm_num == 3'd4);

endmodule

// File: tb/tb_fsm_step_ctrl.sv
module tb_fsm_step_ctrl;

  localparam int CNT_W = 4;
  localparam bit IP    = 1'b1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             req_a, req_b;
  logic [1:0]       cmd_a, cmd_b;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic [2:0]       fsm_num;
  logic gnt_a, gnt_b, done_a, done_b, pause, restart, goto_third, busy, err;

  fsm_step_ctrl #(.CNT_W(CNT_W), .IDLE_PAUSE(IP)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .cmd_a(cmd_a), .cnt_a(cnt_a),
    .req_b(req_b), .cmd_b(cmd_b), .cnt_b(cnt_b),
    .fsm_num(fsm_num),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .pause(pause), .restart(restart), .goto_third(goto_third),
    .busy(busy), .err(err)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- pattern FSM plant ----------------
  logic       fsm_force;
  logic [2:0] fsm_val;
  always @(posedge clk) begin
    if (fsm_force)        fsm_num <= fsm_val;
    else if (restart)     fsm_num <= 3'd0;
    else if (goto_third)  fsm_num <= 3'd2;
    else if (!pause && fsm_num < 3'd4) fsm_num <= fsm_num + 3'd1;
  end

  // ---------------- behavioural model ----------------
  // record: [8] sets err, [7] gnt_a, [6] gnt_b, [5] done_a, [4] done_b,
  //         [3] pause, [2] restart, [1] goto_third, [0] busy
  function automatic logic [8:0] rec(bit se, bit ga, bit gb, bit da, bit db,
                                     bit pa, bit rs, bit gt, bit bz);
    return {se, ga, gb, da, db, pa, rs, gt, bz};
  endfunction

  logic [8:0] exp_q[$];
  logic [8:0] cur;
  bit         m_idle = 1'b1;
  bit         m_last = 1'b1;
  bit         m_err  = 1'b0;
  bit         started = 1'b0;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      exp_q.delete();
      cur    = rec(0, 0, 0, 0, 0, IP, 0, 0, 0);
      m_idle = 1'b1;
      m_last = 1'b1;
      m_err  = 1'b0;
    end else if (m_idle) begin
      if (req_a || req_b) begin
        bit o;
        logic [1:0] c;
        int n;
        int x;
        o = (req_a && req_b) ? ~m_last : req_b;
        c = o ? cmd_b : cmd_a;
        n = int'(o ? cnt_b : cnt_a);
        if (c == 2'b11) c = 2'b01;
        exp_q.push_back(rec(0, !o, o, 0, 0, IP, 0, 0, 1));
        if (c == 2'b10) begin
          exp_q.push_back(rec(0, !o, o, 0, 0, 1, 1, 0, 1));
        end else if (n != 0) begin
          if (c == 2'b00) begin
            x = int'(fsm_num);
            if (x > 4) begin
              exp_q.push_back(rec(1, !o, o, 0, 0, 1, 1, 0, 0));
            end else begin
              for (int i = 0; i < n; i++) begin
                exp_q.push_back(rec(0, !o, o, 0, 0, 0, 0, x == 4, 1));
                x = (x == 4) ? 2 : x + 1;
              end
            end
          end else begin
            for (int i = 0; i < n; i++) exp_q.push_back(rec(0, !o, o, 0, 0, 1, 0, 0, 1));
          end
        end
        exp_q.push_back(rec(0, !o, o, !o, o, IP, 0, 0, 1));
        m_last = o;
        m_idle = 1'b0;
        cur = exp_q.pop_front();
      end
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else begin
      cur    = rec(0, 0, 0, 0, 0, IP, 0, 0, 0);
      m_idle = 1'b1;
    end
    if (cur[8]) m_err = 1'b1;
  end

  // ---------------- scoreboard compare + monitor ----------------
  int pause_lo, goto_hi, restart_hi, done_a_n, done_b_n;
  logic [1:0] gnt_log[$];
  logic       prev_ga = 1'b0, prev_gb = 1'b0;

  always @(negedge clk) begin
    logic [8:0] act, expv;
    if (started) begin
      act  = {err, gnt_a, gnt_b, done_a, done_b, pause, restart, goto_third, busy};
      expv = {m_err, cur[7:0]};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got=%b want=%b (err,ga,gb,da,db,pause,rst,goto,busy)",
                 $time, act, expv);
      end
      checks++;
      if ((gnt_a & gnt_b) !== 1'b0) begin
        errors++;
        $display("FAIL gnt_exclusive t=%0t got gnt_a=%b gnt_b=%b want not both", $time, gnt_a, gnt_b);
      end
      if (pause === 1'b0) pause_lo++;
      if (goto_third === 1'b1) goto_hi++;
      if (restart === 1'b1) restart_hi++;
      if (done_a === 1'b1) done_a_n++;
      if (done_b === 1'b1) done_b_n++;
      if (gnt_a && !prev_ga) gnt_log.push_back(2'd0);
      if (gnt_b && !prev_gb) gnt_log.push_back(2'd1);
      prev_ga = gnt_a;
      prev_gb = gnt_b;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic clear_mon();
    pause_lo = 0; goto_hi = 0; restart_hi = 0; done_a_n = 0; done_b_n = 0;
    gnt_log.delete();
  endtask

  task automatic set_fsm(input logic [2:0] v);
    fsm_force = 1'b1;
    fsm_val   = v;
    tick();
    fsm_force = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic serve_a(input logic [1:0] c, input logic [CNT_W-1:0] n, output int lat);
    bit seen = 1'b0;
    lat = 0;
    cmd_a = c; cnt_a = n; req_a = 1'b1;
    for (int k = 1; k <= 60 && !seen; k++) begin
      tick();
      if (done_a) begin seen = 1'b1; lat = k; end
    end
    req_a = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_a_timeout got=none want=pulse within 60 cycles");
    end
  endtask

  task automatic serve_b(input logic [1:0] c, input logic [CNT_W-1:0] n, output int lat);
    bit seen = 1'b0;
    lat = 0;
    cmd_b = c; cnt_b = n; req_b = 1'b1;
    for (int k = 1; k <= 60 && !seen; k++) begin
      tick();
      if (done_b) begin seen = 1'b1; lat = k; end
    end
    req_b = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_b_timeout got=none want=pulse within 60 cycles");
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lat, lat2;
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    cmd_a = 2'b00; cmd_b = 2'b00; cnt_a = '0; cnt_b = '0;
    fsm_force = 1'b1; fsm_val = 3'd0;
    repeat (3) tick();
    check("reset_outputs", int'({err, gnt_a, gnt_b, done_a, done_b, pause, restart, goto_third, busy}),
          int'(9'b0_0000_1000));
    rst = 1'b0;
    fsm_force = 1'b0;
    tick();

    // A: ADVANCE 3 from step 0
    set_fsm(3'd0);
    clear_mon();
    serve_a(2'b00, 4'd3, lat);
    tick(); tick();
    check("adv3_latency", lat, 5);
    check("adv3_pause_lo", pause_lo, 3);
    check("adv3_fsm_end", int'(fsm_num), 3);
    check("adv3_done_pulses", done_a_n, 1);
    check("adv3_gnt_dropped", int'(gnt_a), 0);

    // B: ADVANCE 4 from step 3 -> 3,4,2,3,4
    clear_mon();
    serve_b(2'b00, 4'd4, lat);
    tick(); tick();
    check("adv4_goto_cycles", goto_hi, 1);
    check("adv4_pause_lo", pause_lo, 4);
    check("adv4_fsm_end", int'(fsm_num), 4);
    check("adv4_done_pulses", done_b_n, 1);

    // Arbitration: tie -> A, tie with A re-raised -> B, then A
    do_reset();
    clear_mon();
    fork
      begin serve_a(2'b01, 4'd1, lat); tick(); serve_a(2'b01, 4'd1, lat); end
      begin serve_b(2'b01, 4'd1, lat2); end
    join
    tick(); tick();
    check("arb_grants", gnt_log.size(), 3);
    if (gnt_log.size() == 3) begin
      check("arb_order", int'({gnt_log[0][0], gnt_log[1][0], gnt_log[2][0]}), int'(3'b010));
    end

    // A: HOLD 0 -> done 2 cycles after request, pause never low
    clear_mon();
    serve_a(2'b01, 4'd0, lat);
    tick(); tick();
    check("hold0_latency", lat, 2);
    check("hold0_pause_lo", pause_lo, 0);

    // A: reserved command runs as HOLD
    clear_mon();
    serve_a(2'b11, 4'd2, lat);
    tick(); tick();
    check("rsvd_latency", lat, 4);
    check("rsvd_pause_lo", pause_lo, 0);

    // A: RESTART from step 3
    set_fsm(3'd3);
    clear_mon();
    serve_a(2'b10, 4'd7, lat);
    tick(); tick();
    check("restart_pulses", restart_hi, 1);
    check("restart_fsm_end", int'(fsm_num), 0);
    check("restart_latency", lat, 3);

    // A: ADVANCE 5 with the FSM stuck at illegal step 6
    fsm_force = 1'b1; fsm_val = 3'd6;
    tick();
    clear_mon();
    serve_a(2'b00, 4'd5, lat);
    tick(); tick();
    check("illegal_err", int'(err), 1);
    check("illegal_restart_pulses", restart_hi, 1);
    check("illegal_pause_lo", pause_lo, 0);
    check("illegal_done_pulses", done_a_n, 1);
    serve_b(2'b01, 4'd1, lat);
    tick(); tick();
    check("err_sticky", int'(err), 1);
    fsm_force = 1'b0;
    set_fsm(3'd0);

    // Reset in the middle of a B HOLD 8
    do_reset();
    check("err_cleared", int'(err), 0);
    clear_mon();
    cmd_b = 2'b01; cnt_b = 4'd8; req_b = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1; req_b = 1'b0;
    tick();
    check("midrst_outputs", int'({err, gnt_a, gnt_b, done_a, done_b, pause, restart, goto_third, busy}),
          int'(9'b0_0000_1000));
    rst = 1'b0;
    repeat (4) tick();
    check("midrst_no_done", done_b_n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=bench end");
    $fatal(1, "watchdog");
  end

endmodule
